// File: rtl/ftdi_pkg.sv
// Shared types and helpers for the FT232H synchronous 245-FIFO receive path.
//   ftdi_rx_state_t : receive FSM states (IDLE, TURN, READ, STOP)
//   FTDI_DATA_W     : width of the FTDI data bus
//   has_room()      : true while at least `headroom` slots stay free
package ftdi_pkg;

    localparam int unsigned FTDI_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        READ = 2'd2,
        STOP = 2'd3
    } ftdi_rx_state_t;

    function automatic logic has_room(input int unsigned depth,
                                      input int unsigned headroom,
                                      input int unsigned occupancy);
        return (occupancy + headroom) <= depth;
    endfunction

endpackage

// File: rtl/ft_sync_fifo.sv
// Single-clock FIFO with a registered read port.
// A pushed entry becomes visible on pop_valid/pop_data one cycle after the push;
// there is no fall-through path from push_data to pop_data.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   push/push_data : write one entry (ignored while full)
//   pop            : consume the entry shown on pop_data (ignored while !pop_valid)
//   pop_data       : registered head entry
//   pop_valid      : pop_data holds a real entry
//   level          : occupancy, 0..DEPTH
//   full, empty    : occupancy flags
module ft_sync_fifo #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              do_push, do_pop;

    always_comb begin
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty   = (wr_ptr_q == rd_ptr_q);
        level   = wr_ptr_q - rd_ptr_q;
        do_push = push && !full;
        do_pop  = pop && valid_q;

        wr_ptr_d = wr_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        rd_ptr_d = rd_ptr_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // The output register is refilled from the pre-edge write pointer, so a
        // byte written this cycle is only shown on the following one.
        valid_d = (wr_ptr_q != rd_ptr_d);
        dout_d  = mem_q[rd_ptr_d[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            dout_q   <= dout_d;
        end
    end

    assign pop_data  = dout_q;
    assign pop_valid = valid_q;

endmodule

// File: rtl/ft232h_rx.sv
// FT232H synchronous 245-FIFO receive path (host -> FTDI -> FPGA), ftdi_clk domain.
// Drives oe_n/rd_n from rxf_n, captures bytes into a local buffer and presents
// them as an AXI-Stream master.
// Ports:
//   ftdi_clk, ftdi_rst_n : 60 MHz FTDI clock, synchronous active-low reset
//   rxf_n                : low while the FTDI holds unread data
//   data                 : FTDI data bus (valid while oe_n=0)
//   oe_n, rd_n           : FTDI output enable and read strobe (registered)
//   rx_enable            : arbiter grant; no new burst starts while low
//   rx_busy              : high whenever the pins are owned by this path
//   m_axis_*             : received byte stream
//   fifo_level           : buffer occupancy
//   overflow_err         : sticky, a byte arrived while the buffer was full
module ft232h_rx
    import ftdi_pkg::*;
#(
    parameter  int unsigned DEPTH    = 16,
    parameter  int unsigned HEADROOM = 2,
    localparam int unsigned LW       = $clog2(DEPTH) + 1
) (
    input  logic                   ftdi_clk,
    input  logic                   ftdi_rst_n,
    input  logic                   rxf_n,
    input  logic [FTDI_DATA_W-1:0] data,
    output logic                   oe_n,
    output logic                   rd_n,
    input  logic                   rx_enable,
    output logic                   rx_busy,
    output logic [FTDI_DATA_W-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [LW-1:0]          fifo_level,
    output logic                   overflow_err
);

    ftdi_rx_state_t state_q, state_d;
    logic           oe_n_q, oe_n_d;
    logic           rd_n_q, rd_n_d;
    logic           rx_busy_q, rx_busy_d;
    logic           overflow_err_q, overflow_err_d;

    logic push, pop;
    logic fifo_full, fifo_empty;
    logic room_idle, room_read;

    always_comb begin
        // The FTDI presents a byte only while our strobe is low and rxf_n still low.
        push = !rd_n_q && !rxf_n;
        pop  = m_axis_tvalid && m_axis_tready;

        room_idle = fifo_empty || has_room(DEPTH, HEADROOM, 32'(fifo_level));
        // In READ the byte captured on this edge is already committed, so the
        // decision to keep rd_n low counts it against the free space.
        room_read = has_room(DEPTH, HEADROOM, 32'(fifo_level) + 32'(push));

        state_d = state_q;
        unique case (state_q)
            IDLE: if (!rxf_n && rx_enable && room_idle) state_d = TURN;
            TURN: state_d = rxf_n ? STOP : READ;
            READ: if (rxf_n || !rx_enable || !room_read) state_d = STOP;
            STOP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        oe_n_d         = (state_d == IDLE);
        rd_n_d         = (state_d != READ);
        rx_busy_d      = (state_d != IDLE);
        overflow_err_d = overflow_err_q || (push && fifo_full);
    end

    always_ff @(posedge ftdi_clk) begin
        if (!ftdi_rst_n) begin
            state_q        <= IDLE;
            oe_n_q         <= 1'b1;
            rd_n_q         <= 1'b1;
            rx_busy_q      <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            oe_n_q         <= oe_n_d;
            rd_n_q         <= rd_n_d;
            rx_busy_q      <= rx_busy_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    ft_sync_fifo #(
        .DATA_W (FTDI_DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (ftdi_clk),
        .rst_n     (ftdi_rst_n),
        .push      (push),
        .push_data (data),
        .pop       (pop),
        .pop_data  (m_axis_tdata),
        .pop_valid (m_axis_tvalid),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign oe_n         = oe_n_q;
    assign rd_n         = rd_n_q;
    assign rx_busy      = rx_busy_q;
    assign overflow_err = overflow_err_q;

endmodule
